clk_div_multi: RTL and testbench

// - NCH independent programmable clock-enable generators sharing one system clock.
// - Each channel emits a 1-cycle tick every (period+1) cycles and a duty-programmable level.
// - Run-time reprogramming through a write port; shadow registers make changes glitch-free at wrap.
// - Global sync realigns all channels.
// - Feeds the slow-clock, display-refresh and debug-blink logic of the MIPS board top.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 97 +++++++++
 rtl/clk_div_multi.sv | 76 +++++++
 tb/tb_clk_div_multi.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// Shared definitions for the multi-channel clock-enable divider.
// - DEF_PERIOD_C / DEF_HIGH_C: power-up period and high count (1 Hz tick,
//   50 % duty from a 50 MHz system clock).
// - ch_w(): width of the configuration channel-select field.
package clk_div_pkg;

    localparam int unsigned DEF_PERIOD_C = 49_999_999;
    localparam int unsigned DEF_HIGH_C   = 25_000_000;

    // One bit wider than a bare index so that an out-of-range channel number
    // is always representable and can be flagged, even when NCH is a power
    // of two.
    function automatic int ch_w(input int nch);
        return $clog2(nch) + 1;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One programmable clock-enable channel.
// Ports:
//   clk, rst_n       system clock, synchronous active-low reset
//   en               run enable; low holds the channel idle at count 0
//   sync             restart at count 0 without emitting a tick
//   wr               configuration write aimed at this channel
//   wr_per, wr_high  new period (cycles-1) and high count for the shadow
//   tick             1-cycle pulse every (period+1) cycles
//   lvl              duty level, high while count < high count
//   pending          shadow written but not yet copied to the active set
module clk_div_chan #(
    parameter int          W          = 28,
    parameter int unsigned DEF_PERIOD = 49_999_999,
    parameter int unsigned DEF_HIGH   = 25_000_000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic         sync,
    input  logic         wr,
    input  logic [W-1:0] wr_per,
    input  logic [W-1:0] wr_high,
    output logic         tick,
    output logic         lvl,
    output logic         pending
);

    typedef struct packed {
        logic [W-1:0] per;
        logic [W-1:0] high;
    } chan_cfg_t;

    localparam chan_cfg_t DEF_CFG = '{per: W'(DEF_PERIOD), high: W'(DEF_HIGH)};

    chan_cfg_t    act_reg, act_next;
    chan_cfg_t    shd_reg, shd_next;
    logic [W-1:0] cnt_reg, cnt_next;
    logic         tick_reg, tick_next;
    logic         lvl_reg, lvl_next;
    logic         pend_reg, pend_next;
    logic         wrap;
    logic         load;

    always_comb begin
        // >= rather than == so a count left above a freshly shortened period
        // (or corrupted) still wraps on the next edge.
        wrap = (cnt_reg >= act_reg.per);
        // Every restart point is a safe place to swap configurations.
        load = !en || sync || wrap;

        // The active set always takes the shadow as it stood before this
        // edge; a write landing on the same edge stays queued in the shadow.
        act_next  = load ? shd_reg : act_reg;
        shd_next  = wr ? '{per: wr_per, high: wr_high} : shd_reg;
        pend_next = wr ? 1'b1 : (load ? 1'b0 : pend_reg);

        cnt_next  = '0;
        tick_next = 1'b0;
        lvl_next  = 1'b0;
        if (!en) begin
            cnt_next = '0;
        end else if (sync) begin
            cnt_next = '0;
        end else if (wrap) begin
            cnt_next  = '0;
            tick_next = 1'b1;
        end else begin
            cnt_next = cnt_reg + W'(1);
        end
        if (en) begin
            lvl_next = (cnt_next < act_next.high);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_reg  <= '0;
            act_reg  <= DEF_CFG;
            shd_reg  <= DEF_CFG;
            tick_reg <= 1'b0;
            lvl_reg  <= 1'b0;
            pend_reg <= 1'b0;
        end else begin
            cnt_reg  <= cnt_next;
            act_reg  <= act_next;
            shd_reg  <= shd_next;
            tick_reg <= tick_next;
            lvl_reg  <= lvl_next;
            pend_reg <= pend_next;
        end
    end

    assign tick    = tick_reg;
    assign lvl     = lvl_reg;
    assign pending = pend_reg;

endmodule

// File: rtl/clk_div_multi.sv
// NCH independent programmable clock-enable generators on one system clock.
// Ports:
//   clk, rst_n    system clock, synchronous active-low reset
//   en_i          per-channel run enable
//   sync_i        restart every channel at count 0
//   wr_en_i       configuration write strobe
//   wr_ch_i       channel index for the write
//   wr_period_i   new period (cycles-1)
//   wr_high_i     new high count
//   tick_o        per-channel 1-cycle pulse each period
//   lvl_o         per-channel duty level
//   pending_o     per-channel shadow-written-not-yet-active flag
//   wr_err_o      1-cycle pulse after a write to a nonexistent channel
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int          NCH        = 4,
    parameter int          W          = 28,
    parameter int unsigned DEF_PERIOD = DEF_PERIOD_C,
    parameter int unsigned DEF_HIGH   = DEF_HIGH_C
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NCH-1:0]         en_i,
    input  logic                   sync_i,
    input  logic                   wr_en_i,
    input  logic [ch_w(NCH)-1:0]   wr_ch_i,
    input  logic [W-1:0]           wr_period_i,
    input  logic [W-1:0]           wr_high_i,
    output logic [NCH-1:0]         tick_o,
    output logic [NCH-1:0]         lvl_o,
    output logic [NCH-1:0]         pending_o,
    output logic                   wr_err_o
);

    localparam int CW = ch_w(NCH);

    logic wr_err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_err_reg <= 1'b0;
        end else begin
            wr_err_reg <= wr_en_i && (wr_ch_i >= CW'(NCH));
        end
    end

    assign wr_err_o = wr_err_reg;

    genvar gi;
    generate
        for (gi = 0; gi < NCH; gi++) begin : g_chan
            logic wr_sel;
            // Out-of-range indices match no channel, so a bad write changes nothing.
            assign wr_sel = wr_en_i && (wr_ch_i == CW'(gi));

            clk_div_chan #(
                .W          (W),
                .DEF_PERIOD (DEF_PERIOD),
                .DEF_HIGH   (DEF_HIGH)
            ) u_chan (
                .clk     (clk),
                .rst_n   (rst_n),
                .en      (en_i[gi]),
                .sync    (sync_i),
                .wr      (wr_sel),
                .wr_per  (wr_period_i),
                .wr_high (wr_high_i),
                .tick    (tick_o[gi]),
                .lvl     (lvl_o[gi]),
                .pending (pending_o[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_div_multi.sv
// Testbench for clk_div_multi: NCH=2, W=8, period 9 / high 5 defaults.
// Each cycle's expected {tick, lvl, pending, wr_err} is queued when the
// stimulus is driven and popped/compared just after the clock edge.
module tb_clk_div_multi;

    logic       clk;
    logic       rst_n;
    logic [1:0] en;
    logic       sync;
    logic       wr_en;
    logic [1:0] wr_ch;
    logic [7:0] wr_per;
    logic [7:0] wr_high;
    logic [1:0] tick;
    logic [1:0] lvl;
    logic [1:0] pending;
    logic       wr_err;

    clk_div_multi #(
        .NCH        (2),
        .W          (8),
        .DEF_PERIOD (9),
        .DEF_HIGH   (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en_i        (en),
        .sync_i      (sync),
        .wr_en_i     (wr_en),
        .wr_ch_i     (wr_ch),
        .wr_period_i (wr_per),
        .wr_high_i   (wr_high),
        .tick_o      (tick),
        .lvl_o       (lvl),
        .pending_o   (pending),
        .wr_err_o    (wr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] en;
        logic       sync;
        logic       wr_en;
        logic [1:0] wr_ch;
        logic [7:0] per;
        logic [7:0] high;
        logic [1:0] tick;
        logic [1:0] lvl;
        logic [1:0] pend;
        logic       err;
    } vec_t;

    typedef struct {
        logic [6:0] v;
        string      nm;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   checks = 0;
    int   passes = 0;
    int   cycle  = 0;

    // Expected {tick, lvl} of a channel n edges after a zero point
    // (count 0, no tick) running with period p and high count h.
    function automatic logic [1:0] wave(input int p, input int h, input int n);
        int c;
        c = n % (p + 1);
        return {(n > 0) && (c == 0), c < h};
    endfunction

    task automatic drive(input logic [1:0] e, input logic s, input logic w,
                         input logic [1:0] ch, input logic [7:0] p, input logic [7:0] h);
        en      = e;
        sync    = s;
        wr_en   = w;
        wr_ch   = ch;
        wr_per  = p;
        wr_high = h;
    endtask

    task automatic cyc(input logic [1:0] t, input logic [1:0] l, input logic [1:0] p,
                       input logic e, input string nm);
        exp_t x;
        x.v  = {t, l, p, e};
        x.nm = nm;
        sb.push_back(x);
        @(posedge clk);
        #1;
        cycle++;
        x = sb.pop_front();
        checks++;
        if ({tick, lvl, pending, wr_err} !== x.v) begin
            $display("FAIL %s cyc=%0d got tick=%b lvl=%b pend=%b err=%b want tick=%b lvl=%b pend=%b err=%b",
                     x.nm, cycle, tick, lvl, pending, wr_err, x.v[6:5], x.v[4:3], x.v[2:1], x.v[0]);
        end else begin
            passes++;
            $display("[%s] cyc=%0d tick=%b lvl=%b pend=%b err=%b ok",
                     x.nm, cycle, tick, lvl, pending, wr_err);
        end
    endtask

    task automatic both(input int p0, input int h0, input int n0,
                        input int p1, input int h1, input int n1,
                        input logic [1:0] pd, input logic e, input string nm);
        logic [1:0] r0;
        logic [1:0] r1;
        r0 = wave(p0, h0, n0);
        r1 = wave(p1, h1, n1);
        cyc({r1[1], r0[1]}, {r1[0], r0[0]}, pd, e, nm);
    endtask

    task automatic add(input logic [1:0] e, input logic s, input logic w, input logic [1:0] ch,
                       input logic [7:0] p, input logic [7:0] h, input logic [1:0] r,
                       input logic [1:0] pd);
        vec_t v;
        v.en = e; v.sync = s; v.wr_en = w; v.wr_ch = ch; v.per = p; v.high = h;
        v.tick = {1'b0, r[1]};
        v.lvl  = {1'b0, r[0]};
        v.pend = pd;
        v.err  = 1'b0;
        tbl.push_back(v);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        drive(2'b00, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);

        // Reset state
        repeat (2) cyc(2'b00, 2'b00, 2'b00, 1'b0, "reset");

        // Vector table: ch0 default 10-cycle period, then reprogram mid-period.
        for (int j = 0; j < 25; j++)
            add(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, wave(9, 5, j + 1), 2'b00);
        add(2'b01, 1'b0, 1'b1, 2'd0, 8'd3, 8'd1, wave(9, 5, 26), 2'b01);
        for (int n = 27; n <= 29; n++)
            add(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, wave(9, 5, n), 2'b01);
        add(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, 2'b11, 2'b00);
        for (int m = 1; m <= 12; m++)
            add(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0, wave(3, 1, m), 2'b00);

        rst_n = 1'b1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].en, tbl[i].sync, tbl[i].wr_en, tbl[i].wr_ch, tbl[i].per, tbl[i].high);
            cyc(tbl[i].tick, tbl[i].lvl, tbl[i].pend, tbl[i].err, "table");
        end

        // Boundaries: per=0, high=0, high>per
        drive(2'b01, 1'b0, 1'b1, 2'd0, 8'd0, 8'd1);
        cyc(2'b00, 2'b00, 2'b01, 1'b0, "t3_wr");
        drive(2'b01, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
        cyc(2'b00, 2'b01, 2'b00, 1'b0, "t3_sync");
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            cyc(2'b01, 2'b01, 2'b00, 1'b0, "t3_per0");
        end
        drive(2'b01, 1'b0, 1'b1, 2'd0, 8'd0, 8'd0);
        cyc(2'b01, 2'b01, 2'b01, 1'b0, "t3_wr_on_wrap");
        for (int k = 0; k < 4; k++) begin
            drive(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            cyc(2'b01, 2'b00, 2'b00, 1'b0, "t3_high0");
        end
        drive(2'b01, 1'b0, 1'b1, 2'd0, 8'd3, 8'd200);
        cyc(2'b01, 2'b00, 2'b01, 1'b0, "t3_wr_big");
        drive(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        cyc(2'b01, 2'b01, 2'b00, 1'b0, "t3_load_big");
        for (int m = 1; m <= 8; m++) begin
            drive(2'b01, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(3, 200, m, 0, 0, 0, 2'b00, 1'b0, "t3_high_gt_per");
        end

        // Both channels with sync
        drive(2'b11, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
        cyc(2'b00, 2'b11, 2'b00, 1'b0, "t4_sync");
        for (int n = 1; n <= 7; n++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(3, 200, n, 9, 5, n, 2'b00, 1'b0, "t4_run");
        end
        drive(2'b11, 1'b1, 1'b0, 2'd0, 8'd0, 8'd0);
        cyc(2'b00, 2'b11, 2'b00, 1'b0, "t4_sync2");
        for (int n = 1; n <= 22; n++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(3, 200, n, 9, 5, n, 2'b00, 1'b0, "t4_lcm");
        end

        // Invalid channel write, then write on ch1's wrap edge
        drive(2'b11, 1'b0, 1'b1, 2'd2, 8'd1, 8'd1);
        both(3, 200, 23, 9, 5, 23, 2'b00, 1'b1, "t5_wr_err");
        for (int n = 24; n <= 29; n++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(3, 200, n, 9, 5, n, 2'b00, 1'b0, "t5_no_change");
        end
        drive(2'b11, 1'b0, 1'b1, 2'd1, 8'd4, 8'd2);
        both(3, 200, 30, 9, 5, 30, 2'b10, 1'b0, "t5_wr_on_wrap");
        for (int n = 31; n <= 39; n++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(3, 200, n, 9, 5, n, 2'b10, 1'b0, "t5_old_active");
        end
        drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        both(3, 200, 40, 9, 5, 40, 2'b00, 1'b0, "t5_new_load");
        for (int m = 1; m <= 5; m++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(3, 200, 40 + m, 4, 2, m, 2'b00, 1'b0, "t5_new_active");
        end

        // Reset mid-count with a pending write
        drive(2'b11, 1'b0, 1'b1, 2'd0, 8'd2, 8'd1);
        both(3, 200, 46, 4, 2, 6, 2'b01, 1'b0, "t6_wr");
        drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
        rst_n = 1'b0;
        cyc(2'b00, 2'b00, 2'b00, 1'b0, "t6_reset");
        rst_n = 1'b1;
        for (int j = 0; j < 12; j++) begin
            drive(2'b11, 1'b0, 1'b0, 2'd0, 8'd0, 8'd0);
            both(9, 5, j + 1, 9, 5, j + 1, 2'b00, 1'b0, "t6_restart");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
